// File: rtl/mem_bus_arbiter.sv
// Two-master (instr fetch / data load-store) to one-slave memory bus arbiter with ack timeout.
// Optional macro ARB_ROUND_ROBIN_EN: alternate ties between masters instead of always favouring data.
module mem_bus_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic [AW-1:0] instr_addr_i,
    input  logic          instr_stb_i,
    output logic [DW-1:0] instr_data_o,
    output logic          instr_ack_o,
    output logic          instr_err_o,
    input  logic [AW-1:0] data_addr_i,
    input  logic [DW-1:0] data_data_i,
    input  logic          data_stb_i,
    input  logic          data_we_i,
    output logic [DW-1:0] data_data_o,
    output logic          data_ack_o,
    output logic          data_err_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_data_o,
    input  logic [DW-1:0] mem_data_i,
    output logic          mem_stb_o,
    output logic          mem_we_o,
    input  logic          mem_ack_i,
    output logic [1:0]    grant_o
);

    // State encoding doubles as the grant_o code.
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] GNT_I = 2'b01;
    localparam logic [1:0] GNT_D = 2'b10;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic [1:0] state, state_nxt;
    logic [7:0] wcnt;
    logic       last_grant_data;  // 0 = instr, 1 = data
    logic       gnt_stb;
    logic       timeout_hit;
    logic [1:0] tie_pick;

    assign grant_o     = state;
    assign timeout_hit = (state != IDLE) && !mem_ack_i && (wcnt == TIMEOUT_CNT);
    assign tie_pick    = (RR_EN && last_grant_data) ? GNT_I : GNT_D;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        mem_addr_o   = '0;
        mem_data_o   = '0;
        mem_stb_o    = 1'b0;
        mem_we_o     = 1'b0;
        instr_data_o = '0;
        instr_ack_o  = 1'b0;
        instr_err_o  = 1'b0;
        data_data_o  = '0;
        data_ack_o   = 1'b0;
        data_err_o   = 1'b0;
        gnt_stb      = 1'b0;
        case (state)
            GNT_I: begin
                gnt_stb      = instr_stb_i;
                mem_addr_o   = instr_addr_i;
                mem_stb_o    = instr_stb_i;
                instr_data_o = mem_data_i;
                instr_ack_o  = mem_ack_i;
                instr_err_o  = timeout_hit;
            end
            GNT_D: begin
                gnt_stb     = data_stb_i;
                mem_addr_o  = data_addr_i;
                mem_data_o  = data_data_i;
                mem_stb_o   = data_stb_i;
                mem_we_o    = data_we_i;
                data_data_o = mem_data_i;
                data_ack_o  = mem_ack_i;
                data_err_o  = timeout_hit;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (instr_stb_i && data_stb_i) state_nxt = tie_pick;
                else if (instr_stb_i)          state_nxt = GNT_I;
                else if (data_stb_i)           state_nxt = GNT_D;
            end
            GNT_I, GNT_D: begin
                // Ack beats timeout; a dropped stb abandons the transfer silently.
                if (mem_ack_i || timeout_hit || !gnt_stb) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state           <= IDLE;
            wcnt            <= '0;
            last_grant_data <= 1'b0;
        end else begin
            state <= state_nxt;
            // Every grant is entered from IDLE, so clearing here clears on entry.
            if (state == IDLE)   wcnt <= '0;
            else if (!mem_ack_i) wcnt <= wcnt + 8'd1;
            if (state == IDLE && state_nxt != IDLE)
                last_grant_data <= (state_nxt == GNT_D);
        end
    end

endmodule
